// File: rtl/tuner_sweep_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// wdm_pkg -- shared types for the ring tuner sweep controller.
//
// Contents:
//   RESULT_W        width of each field in the exported sweep result
//   sweep_state_t   sweep FSM state (IDLE, SETTLE, REQ, WAIT, DONE)
//   sweep_result_t  running best of a sweep: {code, pwr}, zero-extended
//   make_result()   builds a sweep_result_t from two zero-extended fields
// ---------------------------------------------------------------------------
package wdm_pkg;

    // Result fields are sized for the widest DAC/ADC this controller is
    // expected to be built with; narrower codes/samples are zero-extended.
    localparam int RESULT_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_REQ    = 3'd2,
        ST_WAIT   = 3'd3,
        ST_DONE   = 3'd4
    } sweep_state_t;

    typedef struct packed {
        logic [RESULT_W-1:0] code;
        logic [RESULT_W-1:0] pwr;
    } sweep_result_t;

    function automatic sweep_result_t make_result(
        input logic [RESULT_W-1:0] code,
        input logic [RESULT_W-1:0] pwr
    );
        sweep_result_t r;
        r.code = code;
        r.pwr  = pwr;
        return r;
    endfunction

endpackage

// File: rtl/tuner_sweep_ctrl_if.sv
// ---------------------------------------------------------------------------
// tuner_sweep_ctrl_if -- power-detector handshake between the sweep
// controller (master) and the ring power detector (slave).
//
// Signals:
//   o_dig_pwr_read_val       master -> slave  read request
//   i_dig_pwr_read_rdy       slave  -> master read request accepted
//   i_dig_pwr_detect_val     slave  -> master detected power is valid
//   o_dig_pwr_detect_rdy     master -> slave  master can take a sample
//   i_dig_ring_pwr_detected  slave  -> master detected thru power sample
//
// Handshake: each channel transfers on a rising edge where both valid and
// ready are 1. The master keeps read_val high, without changing the tuning
// code, until read_rdy is seen; detect_val is only acted on while the master
// holds detect_rdy high, so pulses at any other time are dropped.
// ---------------------------------------------------------------------------
interface tuner_sweep_ctrl_if #(
    parameter int ADC_WIDTH = 8
);
    logic                 o_dig_pwr_read_val;
    logic                 i_dig_pwr_read_rdy;
    logic                 i_dig_pwr_detect_val;
    logic                 o_dig_pwr_detect_rdy;
    logic [ADC_WIDTH-1:0] i_dig_ring_pwr_detected;

    modport master (
        output o_dig_pwr_read_val,
        output o_dig_pwr_detect_rdy,
        input  i_dig_pwr_read_rdy,
        input  i_dig_pwr_detect_val,
        input  i_dig_ring_pwr_detected
    );

    modport slave (
        input  o_dig_pwr_read_val,
        input  o_dig_pwr_detect_rdy,
        output i_dig_pwr_read_rdy,
        output i_dig_pwr_detect_val,
        output i_dig_ring_pwr_detected
    );
endinterface

// File: rtl/tuner_sweep_ctrl_settle_timer.sv
// ---------------------------------------------------------------------------
// tuner_settle_timer -- counts the thermal-settle wait for one DAC code.
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   load        clear the count (held while not settling)
//   count       advance the count by one each cycle
//   expire      high in the last of CYCLES counting cycles
// ---------------------------------------------------------------------------
module tuner_settle_timer #(
    parameter int CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count,
    output logic expire
);
    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + CW'(1);
        end
    end

    // Counting starts at 0, so expire in the CYCLES-th counting cycle.
    assign expire = count && (cnt == CW'(CYCLES - 1));
endmodule

// File: rtl/tuner_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tuner_sweep_ctrl -- sweeps a ring tuning DAC from min to max in steps,
// waits for the ring to settle at each code, reads the detected thru power
// and reports the code with the lowest power (resonance).
//
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_sweep_start         start pulse, sampled only when idle
//   i_dac_code_min/max    sweep range (min > max gives a single point at min)
//   i_dac_code_step       code increment (0 is treated as 1)
//   pwr                   power-detector handshake (master side)
//   o_dac_tune            code driven to the tuning DAC
//   o_busy                high whenever the sweep FSM is not idle
//   o_done                one-cycle pulse at the end of a sweep
//   o_best_code/o_best_pwr  result of the last completed sweep
//   o_dbg_state           current FSM state
//   o_dbg_result          running best of the sweep in progress
//
// Build option: define TUNER_SWEEP_LOCK_EN to park o_dac_tune on the best
// code once a sweep completes; otherwise it keeps the last swept code.
// ---------------------------------------------------------------------------
module tuner_sweep_ctrl
    import wdm_pkg::*;
#(
    parameter int DAC_WIDTH     = 8,
    parameter int ADC_WIDTH     = 8,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_sweep_start,
    input  logic [DAC_WIDTH-1:0] i_dac_code_min,
    input  logic [DAC_WIDTH-1:0] i_dac_code_max,
    input  logic [DAC_WIDTH-1:0] i_dac_code_step,
    tuner_sweep_ctrl_if.master   pwr,
    output logic [DAC_WIDTH-1:0] o_dac_tune,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [DAC_WIDTH-1:0] o_best_code,
    output logic [ADC_WIDTH-1:0] o_best_pwr,
    output sweep_state_t         o_dbg_state,
    output sweep_result_t        o_dbg_result
);
    localparam logic [ADC_WIDTH-1:0] PWR_ONES = {ADC_WIDTH{1'b1}};

    sweep_state_t          state;
    sweep_result_t         run_best;
    logic [DAC_WIDTH-1:0]  max_r;
    logic [DAC_WIDTH-1:0]  step_r;

    logic                  settle_active;
    logic                  settle_expire;
    logic [DAC_WIDTH-1:0]  run_code;
    logic [ADC_WIDTH-1:0]  run_pwr;
    logic                  sample_better;
    logic [DAC_WIDTH-1:0]  nxt_code;
    logic [ADC_WIDTH-1:0]  nxt_pwr;
    logic [DAC_WIDTH:0]    step_sum;
    logic                  sweep_last;

    assign settle_active = (state == ST_SETTLE);

    tuner_settle_timer #(
        .CYCLES(SETTLE_CYCLES)
    ) u_settle (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .load  (!settle_active),
        .count (settle_active),
        .expire(settle_expire)
    );

    assign run_code = run_best.code[DAC_WIDTH-1:0];
    assign run_pwr  = run_best.pwr[ADC_WIDTH-1:0];

    // Strict compare: ties keep the earlier (lower) code, and an all-ones
    // sample can never beat the all-ones starting value.
    assign sample_better = (pwr.i_dig_ring_pwr_detected < run_pwr);
    assign nxt_code      = sample_better ? o_dac_tune : run_code;
    assign nxt_pwr       = sample_better ? pwr.i_dig_ring_pwr_detected : run_pwr;

    // One extra bit so a step past the top of the DAC range ends the sweep
    // instead of wrapping back to a low code.
    assign step_sum   = {1'b0, o_dac_tune} + {1'b0, step_r};
    assign sweep_last = (step_sum > {1'b0, max_r});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state                    <= ST_IDLE;
            run_best                 <= make_result('0, RESULT_W'(PWR_ONES));
            max_r                    <= '0;
            step_r                   <= '0;
            o_dac_tune               <= '0;
            o_done                   <= 1'b0;
            o_best_code              <= '0;
            o_best_pwr               <= PWR_ONES;
            pwr.o_dig_pwr_read_val   <= 1'b0;
            pwr.o_dig_pwr_detect_rdy <= 1'b0;
        end else begin
            o_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_sweep_start) begin
                        max_r      <= i_dac_code_max;
                        step_r     <= (i_dac_code_step == '0) ? DAC_WIDTH'(1)
                                                              : i_dac_code_step;
                        o_dac_tune <= i_dac_code_min;
                        // Seeding the best code with min makes an all-ones
                        // sweep report min.
                        run_best   <= make_result(RESULT_W'(i_dac_code_min),
                                                  RESULT_W'(PWR_ONES));
                        state      <= ST_SETTLE;
                    end
                end
                ST_SETTLE: begin
                    if (settle_expire) begin
                        pwr.o_dig_pwr_read_val <= 1'b1;
                        state                  <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (pwr.i_dig_pwr_read_rdy) begin
                        pwr.o_dig_pwr_read_val   <= 1'b0;
                        pwr.o_dig_pwr_detect_rdy <= 1'b1;
                        state                    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (pwr.i_dig_pwr_detect_val) begin
                        pwr.o_dig_pwr_detect_rdy <= 1'b0;
                        run_best <= make_result(RESULT_W'(nxt_code), RESULT_W'(nxt_pwr));
                        if (sweep_last) begin
                            o_done      <= 1'b1;
                            o_best_code <= nxt_code;
                            o_best_pwr  <= nxt_pwr;
`ifdef TUNER_SWEEP_LOCK_EN
                            o_dac_tune  <= nxt_code;
`endif
                            state       <= ST_DONE;
                        end else begin
                            o_dac_tune <= step_sum[DAC_WIDTH-1:0];
                            state      <= ST_SETTLE;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_busy       = (state != ST_IDLE);
    assign o_dbg_state  = state;
    assign o_dbg_result = run_best;
endmodule

// File: tb/tb_tuner_sweep_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tuner_sweep_ctrl -- bench for tuner_sweep_ctrl. A stub power detector
// answers reads from a per-test power table; a reference model derives the
// expected read sequence and best result from the sweep rules directly.
// ---------------------------------------------------------------------------
module tb_tuner_sweep_ctrl;
    import wdm_pkg::*;

    localparam int DW = 8;
    localparam int AW = 8;
    localparam int SC = 4;

    typedef struct {
        int mn;
        int mx;
        int st;
        int mode;
        int exp_code;
        int exp_pwr;
        int exp_reads;
    } vec_t;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [DW-1:0] dmin, dmax, dstep;
    logic [DW-1:0] dac, best_code;
    logic [AW-1:0] best_pwr;
    logic          busy, done;
    sweep_state_t  dbg_state;
    sweep_result_t dbg_result;

    tuner_sweep_ctrl_if #(.ADC_WIDTH(AW)) pif ();

    tuner_sweep_ctrl #(
        .DAC_WIDTH    (DW),
        .ADC_WIDTH    (AW),
        .SETTLE_CYCLES(SC)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_sweep_start  (start),
        .i_dac_code_min (dmin),
        .i_dac_code_max (dmax),
        .i_dac_code_step(dstep),
        .pwr            (pif),
        .o_dac_tune     (dac),
        .o_busy         (busy),
        .o_done         (done),
        .o_best_code    (best_code),
        .o_best_pwr     (best_pwr),
        .o_dbg_state    (dbg_state),
        .o_dbg_result   (dbg_result)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int            n_checks;
    int            n_fail;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] obs_q[$];
    int            pwr_tab[256];
    int            rd_delay;
    int            dv_delay;
    bit            spur_en;
    int            stall_bad;

    int r_code, r_pwr, r_dac_done, r_dac_idle, r_busy_done, r_busy_idle, r_ndone;
    bit r_tmo;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // ---------------- stub power detector ----------------
    task automatic det_service();
        logic [DW-1:0] code;
        int k;
        code = dac;
        k = 0;
        while (k < rd_delay) begin
            if (pif.o_dig_pwr_read_val !== 1'b1 || dac !== code) stall_bad++;
            @(negedge clk);
            if (!rst_n) return;
            k++;
        end
        if (pif.o_dig_pwr_read_val !== 1'b1 || dac !== code) stall_bad++;
        pif.i_dig_pwr_read_rdy = 1'b1;
        obs_q.push_back(code);
        @(negedge clk);
        pif.i_dig_pwr_read_rdy = 1'b0;
        if (!rst_n) return;
        k = 0;
        while (k < dv_delay) begin
            if (pif.o_dig_pwr_detect_rdy !== 1'b1 || dac !== code) stall_bad++;
            @(negedge clk);
            if (!rst_n) return;
            k++;
        end
        if (pif.o_dig_pwr_detect_rdy !== 1'b1 || dac !== code) stall_bad++;
        pif.i_dig_pwr_detect_val    = 1'b1;
        pif.i_dig_ring_pwr_detected = AW'(pwr_tab[code]);
    endtask

    initial begin
        pif.i_dig_pwr_read_rdy      = 1'b0;
        pif.i_dig_pwr_detect_val    = 1'b0;
        pif.i_dig_ring_pwr_detected = '0;
        forever begin
            @(negedge clk);
            pif.i_dig_pwr_read_rdy      = 1'b0;
            pif.i_dig_pwr_detect_val    = 1'b0;
            pif.i_dig_ring_pwr_detected = '0;
            if (rst_n && pif.o_dig_pwr_read_val === 1'b1) begin
                det_service();
            end else if (spur_en && rst_n && pif.o_dig_pwr_detect_rdy !== 1'b1) begin
                // Stray zero-power samples the controller must not take.
                if ($urandom_range(0, 3) == 0) pif.i_dig_pwr_detect_val = 1'b1;
            end
        end
    end

    // ---------------- power tables and reference model ----------------
    task automatic fill_tab(input int mode);
        for (int c = 0; c < 256; c++) begin
            case (mode)
                0: pwr_tab[c] = ((c > 5 ? c - 5 : 5 - c) * 10 > 255) ? 255
                              : (c > 5 ? c - 5 : 5 - c) * 10;
                1: pwr_tab[c] = 255 - c;
                2: pwr_tab[c] = (c == 0) ? 40 : (c == 1) ? 20 : (c == 2) ? 20 : (c == 3) ? 30 : 255;
                3: pwr_tab[c] = 255;
                default: pwr_tab[c] = ($urandom_range(0, 7) == 0) ? 255 : $urandom_range(0, 7) * 30;
            endcase
        end
    endtask

    // Codes visited are min, min+step, ... while not above max (at least
    // min); best is the first lowest sample, starting from all-ones at min.
    task automatic model(input int mn, input int mx, input int st,
                         output int bc, output int bp, output int last);
        int s, c;
        exp_q.delete();
        s  = (st == 0) ? 1 : st;
        c  = mn;
        bc = mn;
        bp = 255;
        last = mn;
        do begin
            exp_q.push_back(DW'(c));
            if (pwr_tab[c] < bp) begin
                bp = pwr_tab[c];
                bc = c;
            end
            last = c;
            c = c + s;
        end while (c <= mx);
    endtask

    // ---------------- driver ----------------
    task automatic run_sweep(input int mn, input int mx, input int st);
        int cyc;
        bit seen;
        obs_q.delete();
        stall_bad = 0;
        r_ndone = 0;
        r_code = -1; r_pwr = -1; r_dac_done = -1; r_busy_done = -1;
        @(negedge clk);
        dmin  = DW'(mn);
        dmax  = DW'(mx);
        dstep = DW'(st);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        seen = 0;
        while (!seen && cyc < 20000) begin
            if (done === 1'b1) begin
                seen        = 1;
                r_ndone++;
                r_code      = int'(best_code);
                r_pwr       = int'(best_pwr);
                r_dac_done  = int'(dac);
                r_busy_done = int'(busy);
            end else begin
                // A start while busy, with different range inputs, must be ignored.
                if (cyc == 1 && busy === 1'b1) begin
                    start = 1'b1;
                    dmin  = DW'($urandom);
                    dmax  = DW'($urandom);
                    dstep = DW'($urandom);
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                cyc++;
            end
        end
        r_tmo = !seen;
        start = 1'b0;
        @(negedge clk);
        r_dac_idle  = int'(dac);
        r_busy_idle = int'(busy);
        for (int k = 0; k < 4; k++) begin
            if (done === 1'b1) r_ndone++;
            @(negedge clk);
        end
    endtask

    task automatic check_run(input string tag, input int ec, input int ep, input int elast);
        int exp_dac;
        int n;
`ifdef TUNER_SWEEP_LOCK_EN
        exp_dac = ec;
`else
        exp_dac = elast;
`endif
        check({tag, "_timeout"}, r_tmo, 0);
        check({tag, "_done_pulses"}, r_ndone, 1);
        check({tag, "_best_code"}, r_code, ec);
        check({tag, "_best_pwr"}, r_pwr, ep);
        check({tag, "_busy_at_done"}, r_busy_done, 1);
        check({tag, "_busy_after"}, r_busy_idle, 0);
        check({tag, "_dac_at_done"}, r_dac_done, exp_dac);
        check({tag, "_dac_idle"}, r_dac_idle, exp_dac);
        check({tag, "_stall"}, stall_bad, 0);
        check({tag, "_n_reads"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_read%0d", tag, i), obs_q[i], exp_q[i]);
        end
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs[8];

    initial begin
        int m_code, m_pwr, m_last;
        int base_code, base_pwr;
        int cyc, nd;
        int mn, mx, st;

        vecs[0] = '{mn:0,   mx:9,   st:1,   mode:0, exp_code:5,   exp_pwr:0,   exp_reads:10};
        vecs[1] = '{mn:250, mx:255, st:4,   mode:1, exp_code:254, exp_pwr:1,   exp_reads:2};
        vecs[2] = '{mn:7,   mx:7,   st:0,   mode:0, exp_code:7,   exp_pwr:20,  exp_reads:1};
        vecs[3] = '{mn:9,   mx:3,   st:0,   mode:0, exp_code:9,   exp_pwr:40,  exp_reads:1};
        vecs[4] = '{mn:0,   mx:3,   st:1,   mode:2, exp_code:1,   exp_pwr:20,  exp_reads:4};
        vecs[5] = '{mn:10,  mx:20,  st:5,   mode:3, exp_code:10,  exp_pwr:255, exp_reads:3};
        vecs[6] = '{mn:3,   mx:8,   st:2,   mode:0, exp_code:5,   exp_pwr:0,   exp_reads:3};
        vecs[7] = '{mn:0,   mx:255, st:255, mode:1, exp_code:255, exp_pwr:0,   exp_reads:2};

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        dmin     = '0;
        dmax     = '0;
        dstep    = '0;
        rd_delay = 0;
        dv_delay = 0;
        spur_en  = 0;
        base_code = 0;
        base_pwr  = 0;

        repeat (3) @(negedge clk);
        check("rst_state", dbg_state, ST_IDLE);
        check("rst_dac", dac, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_best_code", best_code, 0);
        check("rst_best_pwr", best_pwr, 255);
        check("rst_read_val", pif.o_dig_pwr_read_val, 0);
        check("rst_detect_rdy", pif.o_dig_pwr_detect_rdy, 0);
        rst_n = 1'b1;

        // Table-driven directed sweeps.
        for (int i = 0; i < 8; i++) begin
            fill_tab(vecs[i].mode);
            model(vecs[i].mn, vecs[i].mx, vecs[i].st, m_code, m_pwr, m_last);
            run_sweep(vecs[i].mn, vecs[i].mx, vecs[i].st);
            check($sformatf("v%0d_table_reads", i), obs_q.size(), vecs[i].exp_reads);
            check_run($sformatf("v%0d", i), vecs[i].exp_code, vecs[i].exp_pwr, m_last);
            if (i == 0) begin
                base_code = r_code;
                base_pwr  = r_pwr;
            end
        end

        // Backpressure on both handshakes: result must match the unstalled run.
        fill_tab(0);
        model(0, 9, 1, m_code, m_pwr, m_last);
        rd_delay = 20;
        dv_delay = 15;
        run_sweep(0, 9, 1);
        check_run("stall", vecs[0].exp_code, vecs[0].exp_pwr, m_last);
        check("stall_vs_base_code", r_code, base_code);
        check("stall_vs_base_pwr", r_pwr, base_pwr);
        rd_delay = 0;
        dv_delay = 0;

        // Reset while waiting for a detected sample.
        dv_delay = 30;
        @(negedge clk);
        dmin  = 8'd0;
        dmax  = 8'd9;
        dstep = 8'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (dbg_state !== ST_WAIT && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check("rw_reach_wait", dbg_state, ST_WAIT);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rw_state", dbg_state, ST_IDLE);
        check("rw_dac", dac, 0);
        check("rw_read_val", pif.o_dig_pwr_read_val, 0);
        check("rw_detect_rdy", pif.o_dig_pwr_detect_rdy, 0);
        check("rw_busy", busy, 0);
        check("rw_done", done, 0);
        check("rw_best_code", best_code, 0);
        check("rw_best_pwr", best_pwr, 255);
        nd = 0;
        repeat (4) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        dv_delay = 0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("rw_no_done", nd, 0);
        model(0, 9, 1, m_code, m_pwr, m_last);
        run_sweep(0, 9, 1);
        check_run("rw_restart", m_code, m_pwr, m_last);

        // Randomized sweeps against the reference model.
        spur_en = 1;
        for (int t = 0; t < 10; t++) begin
            mn = $urandom_range(0, 255);
            if ($urandom_range(0, 4) == 0) mx = $urandom_range(0, 255);
            else mx = (mn + $urandom_range(0, 60) > 255) ? 255 : mn + $urandom_range(0, 60);
            st = $urandom_range(0, 12);
            rd_delay = $urandom_range(0, 3);
            dv_delay = $urandom_range(0, 3);
            fill_tab(4);
            model(mn, mx, st, m_code, m_pwr, m_last);
            run_sweep(mn, mx, st);
            check_run($sformatf("rnd%0d", t), m_code, m_pwr, m_last);
        end
        spur_en = 0;

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tuner_sweep_ctrl.md
TUNER_SWEEP_CTRL -- requirements
Module: tuner_sweep_ctrl

Interface
REQ-001 SHALL have parameter DAC_WIDTH, default 8, tuning DAC code width.
REQ-002 SHALL have parameter ADC_WIDTH, default 8, detected-power sample width.
REQ-003 SHALL have parameter SETTLE_CYCLES, default 4, ring thermal-settle wait per code (>=1).
REQ-004 SHALL have one clock and an asynchronous, active-low reset: i_clk in 1 (rising edge), then i_rst_n in 1.
REQ-005 SHALL have the control and sweep ports: i_sweep_start in 1 (start pulse); i_dac_code_min in DAC_WIDTH; i_dac_code_max in DAC_WIDTH; i_dac_code_step in DAC_WIDTH.
REQ-006 SHALL have the power-detect handshake ports: o_dig_pwr_read_val out 1 (read request to power detector); i_dig_pwr_read_rdy in 1; i_dig_pwr_detect_val in 1; o_dig_pwr_detect_rdy out 1; i_dig_ring_pwr_detected in ADC_WIDTH (detected thru power).
REQ-007 SHALL have the output ports: o_dac_tune out DAC_WIDTH (to tuning DAC); o_busy out 1; o_done out 1 (one-cycle pulse); o_best_code out DAC_WIDTH; o_best_pwr out ADC_WIDTH.

Function
REQ-008 SHALL implement FSM IDLE -> SETTLE -> REQ -> WAIT -> (SETTLE | DONE) -> IDLE.
REQ-009 In IDLE, when i_sweep_start=1, SHALL latch min, max and step; set o_dac_tune=min; reset best_pwr to all-ones; go to SETTLE next cycle.
REQ-010 A step of 0 SHALL be treated as 1; if min>max, the sweep SHALL be a single point at min.
REQ-011 SETTLE SHALL hold o_dac_tune for exactly SETTLE_CYCLES cycles, then go to REQ.
REQ-012 REQ SHALL assert o_dig_pwr_read_val until the cycle where i_dig_pwr_read_rdy=1, then go to WAIT.
REQ-013 WAIT SHALL assert o_dig_pwr_detect_rdy; on i_dig_pwr_detect_val=1 it SHALL capture i_dig_ring_pwr_detected; detect_val outside WAIT SHALL be ignored.
REQ-014 If sample < best_pwr (strict), SHALL update best_pwr=sample and best_code=o_dac_tune; ties SHALL keep the earlier (lower) code.
REQ-015 Next code SHALL be computed at DAC_WIDTH+1 bits; if code+step > max or carries out, SHALL go to DONE, else set o_dac_tune=code+step and go to SETTLE.
REQ-016 DONE SHALL pulse o_done for one cycle, update o_best_code/o_best_pwr in that cycle, and return to IDLE.
REQ-017 o_busy SHALL be 1 in every state except IDLE.
REQ-018 i_sweep_start while busy SHALL be ignored.
REQ-019 o_best_code/o_best_pwr SHALL hold their values until the next DONE.
REQ-020 A sample equal to all-ones SHALL never update best; if all samples are all-ones, best_code SHALL be min.

Reset
REQ-021 Asserting i_rst_n=0 at any time, including mid-sweep, SHALL force state IDLE, o_dac_tune=0, o_dig_pwr_read_val=0, o_dig_pwr_detect_rdy=0, o_busy=0, o_done=0, o_best_code=0, o_best_pwr=all-ones, and SETTLE counter 0.
REQ-022 After reset release, the block SHALL accept a start no earlier than the first rising edge.

Configuration
REQ-023 Macro TUNER_SWEEP_LOCK_EN: when defined, DONE and IDLE (after at least one completed sweep) SHALL drive o_dac_tune=best_code.
REQ-024 Without TUNER_SWEEP_LOCK_EN, o_dac_tune SHALL keep the last swept code after DONE.

Structure
REQ-025 The FSM state enum and the sweep-result struct (code, pwr) SHALL live in the shared wdm_pkg.
REQ-026 The settle counter SHALL be one sub-module, tuner_settle_timer (load, count, expire), with no other sub-modules.

Verification
REQ-027 Sweep: min=0, max=9, step=1. The stub detector returns |code-5|*10. Required: 10 reads, o_best_code=5, o_best_pwr=0, one o_done pulse.
REQ-028 Wrap: min=250, max=255, step=4. Required: codes 250 and 254 only, no overflow to 2, then DONE.
REQ-029 Degenerate: step=0 and min=max=7. Required: a single read at code 7, best_code=7. A second case with min=9, max=3 requires a single read at 9.
REQ-030 Backpressure: hold read_rdy low for 20 cycles and delay detect_val 15 cycles. Required: read_val stays high, o_dac_tune stays stable, and the result matches the no-stall run.
REQ-031 Reset mid-WAIT: assert i_rst_n=0. Required: all REQ-021 values in the same cycle, and no o_done. A restart then completes normally.
REQ-032 Ties and lock: samples {40,20,20,30} for codes 0..3. Required: best_code=1. With TUNER_SWEEP_LOCK_EN, o_dac_tune=1 after DONE; without it, o_dac_tune=3.
